// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the word-address PC, tracks one in-flight read of a
// 1-cycle-latency instruction memory, and buffers returned words for decode.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_en,
    output logic [31:0] imem_pc,
    input  logic [31:0] imem_instruction,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instruction,
    output logic [31:0] out_pc
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W:0]   DEPTH_C = (CNT_W + 1)'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(DEPTH - 1);

    logic [31:0]      r_fetch_pc;
    logic             r_inflight;
    logic [31:0]      r_inflight_pc;
    logic [31:0]      r_buf_instr [DEPTH];
    logic [31:0]      r_buf_pc    [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;

    logic             w_pop;
    logic             w_ret;
    logic             w_issue;
    logic [CNT_W:0]   w_occ_after;
    logic [CNT_W-1:0] w_count_nxt;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_C) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_pop = out_valid && out_ready;
    assign w_ret = r_inflight;

    // Credit check counts the in-flight word as already occupying a slot, so a
    // return can never find the buffer full.
    assign w_occ_after = {1'b0, r_count} + (CNT_W + 1)'(r_inflight) - (CNT_W + 1)'(w_pop);
    assign w_issue     = fetch_en && !redirect_valid && (w_occ_after < DEPTH_C);

    always_comb begin
        w_count_nxt = r_count;
        case ({w_ret, w_pop})
            2'b10:   w_count_nxt = r_count + CNT_W'(1);
            2'b01:   w_count_nxt = r_count - CNT_W'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // NOTE: all state below uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would let r_fetch_pc leak into r_inflight_pc.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc    <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_count       <= '0;
            // NOTE: buffer storage is reset on purpose so out_instruction/out_pc read
            // as zero during reset; it is only DEPTH words, not a RAM macro.
            for (int i = 0; i < DEPTH; i++) begin
                r_buf_instr[i] <= '0;
                r_buf_pc[i]    <= '0;
            end
        end else if (redirect_valid) begin
            r_fetch_pc <= redirect_pc;
            r_inflight <= 1'b0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_inflight_pc <= r_fetch_pc;
                r_fetch_pc    <= r_fetch_pc + 32'd1;
            end
            if (w_ret) begin
                r_buf_instr[r_wr_ptr] <= imem_instruction;
                r_buf_pc[r_wr_ptr]    <= r_inflight_pc;
                r_wr_ptr              <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            r_count <= w_count_nxt;
        end
    end

    assign imem_pc         = r_fetch_pc;
    assign out_valid       = (r_count != '0);
    assign out_instruction = r_buf_instr[r_rd_ptr];
    assign out_pc          = r_buf_pc[r_rd_ptr];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory word k holds 0x1000 + k, expected outputs are
// queued by the stimulus and consumed by an independent monitor on each accepted pop.
module tb_fetch_unit;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_en;
    logic [31:0] imem_pc;
    logic [31:0] imem_instruction = 32'd0;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instruction;
    logic [31:0] out_pc;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    fetch_unit #(.RESET_PC(32'd0), .DEPTH(2)) dut (
        .clk              (clk),
        .rst              (rst),
        .fetch_en         (fetch_en),
        .imem_pc          (imem_pc),
        .imem_instruction (imem_instruction),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_instruction  (out_instruction),
        .out_pc           (out_pc)
    );

    always #5 clk = ~clk;

    // Synchronous memory model: one word per cycle, 1-cycle read latency.
    always @(posedge clk) imem_instruction <= imem_pc + 32'h1000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_range(input logic [31:0] start, input int n);
        logic [31:0] pc;
        for (int i = 0; i < n; i++) begin
            pc = start + 32'(i);
            exp_q.push_back('{pc: pc, instr: pc + 32'h1000});
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: every accepted output must match the next queued expectation.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_output: got pc 0x%08h, expected no output", out_pc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("out_pc", out_pc, e.pc);
                check("out_instruction", out_instruction, e.instr);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; fetch_en = 1'b0; out_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 32'd0;
        step(3);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_imem_pc", imem_pc, 32'd0);
        check("rst_out_pc", out_pc, 32'd0);
        check("rst_out_instruction", out_instruction, 32'd0);
        fetch_en = 1'b1; out_ready = 1'b1;
        step(1);
        check("rst_hold_imem_pc", imem_pc, 32'd0);

        // Cycle 0: first cycle out of reset
        rst = 1'b0;
        push_range(32'd0, 8);
        check("c0_out_valid", 32'(out_valid), 32'd0);
        step(1);
        check("c1_out_valid", 32'(out_valid), 32'd0);
        step(1);
        check("c2_out_valid", 32'(out_valid), 32'd1);
        step(3);

        // Cycles 5..14: decode stalls, buffer saturates, PC freezes
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("stall_imem_pc", imem_pc, 32'd5);
            check("stall_out_pc", out_pc, 32'd3);
            check("stall_out_valid", 32'(out_valid), 32'd1);
            step(1);
        end
        out_ready = 1'b1;
        step(5);

        // Cycle 20: redirect discards head pc 8 and in-flight pc 9
        check("c20_imem_pc", imem_pc, 32'd10);
        redirect_valid = 1'b1; redirect_pc = 32'h40; out_ready = 1'b0;
        push_range(32'h40, 5);
        step(1);
        redirect_valid = 1'b0; out_ready = 1'b1;
        check("redir_n1_out_valid", 32'(out_valid), 32'd0);
        check("redir_n1_imem_pc", imem_pc, 32'h40);
        step(1);
        check("redir_n2_out_valid", 32'(out_valid), 32'd0);
        step(1);
        check("redir_n3_out_valid", 32'(out_valid), 32'd1);
        step(4);

        // Cycle 27: redirect with a same-cycle pop, then a second redirect
        redirect_valid = 1'b1; redirect_pc = 32'h80;
        step(1);
        redirect_pc = 32'hC0;
        check("dbl_redir_imem_pc", imem_pc, 32'h80);
        check("dbl_redir_out_valid", 32'(out_valid), 32'd0);
        step(1);
        redirect_valid = 1'b0;
        check("second_target_imem_pc", imem_pc, 32'hC0);
        check("second_target_out_valid", 32'(out_valid), 32'd0);
        push_range(32'hC0, 4);
        step(1);
        check("second_target_next_pc", imem_pc, 32'hC1);
        check("second_target_n2_valid", 32'(out_valid), 32'd0);
        step(1);
        check("second_target_n3_valid", 32'(out_valid), 32'd1);
        step(4);

        // Cycle 35: redirect to the top of the address space
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF; out_ready = 1'b0;
        push_range(32'hFFFF_FFFF, 4);
        step(1);
        redirect_valid = 1'b0; out_ready = 1'b1;
        check("wrap_imem_pc_top", imem_pc, 32'hFFFF_FFFF);
        step(1);
        check("wrap_imem_pc_zero", imem_pc, 32'd0);
        step(5);

        // Fill the buffer, then assert reset between clock edges
        out_ready = 1'b0;
        step(1);
        check("full_out_valid", 32'(out_valid), 32'd1);
        check("full_out_pc", out_pc, 32'd3);
        check("queue_drained_pre_rst", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_out_valid", 32'(out_valid), 32'd0);
        check("async_rst_out_pc", out_pc, 32'd0);
        check("async_rst_out_instruction", out_instruction, 32'd0);
        check("async_rst_imem_pc", imem_pc, 32'd0);
        step(1);

        // Restart from RESET_PC, then drop fetch_en and let in-flight work drain
        rst = 1'b0; out_ready = 1'b1;
        push_range(32'd0, 6);
        check("restart_imem_pc", imem_pc, 32'd0);
        step(6);
        fetch_en = 1'b0;
        step(1);
        check("fetch_off_imem_pc", imem_pc, 32'd6);
        check("fetch_off_last_valid", 32'(out_valid), 32'd1);
        step(1);
        check("fetch_off_drained_valid", 32'(out_valid), 32'd0);
        check("fetch_off_imem_pc_hold", imem_pc, 32'd6);
        step(3);
        check("queue_drained_end", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
